alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits (power of two, 8..64).
REQ-002 SHALL have parameter IMM_W, default 12, the immediate width in bits (IMM_W < WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  an operation is offered.
REQ-006 SHALL have port in_ready  output  1  the block accepts an operation this cycle.
REQ-007 SHALL have port op  input  4  operation code (REQ-016).
REQ-008 SHALL have port use_imm  input  1  operand B is sign-extended imm rather than rs2.
REQ-009 SHALL have port branch  input  1  the operation is a branch; gates pcsrc.
REQ-010 SHALL have port rs1  input  WIDTH  operand A.
REQ-011 SHALL have port rs2  input  WIDTH  operand B register value.
REQ-012 SHALL have port imm  input  IMM_W  two's-complement immediate.
REQ-013 SHALL have port out_valid  output  1  result, cond and pcsrc are valid.
REQ-014 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-015 SHALL have ports result (output, WIDTH, ALU result), cond (output, 1, comparison true) and pcsrc (output, 1, cond & latched branch).

Function
REQ-016 SHALL decode op as follows: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR, 0101 SRA, 0111 SLL, 1000 SRL, 1001 SLT (signed, result 1/0), 1010 MUL (low WIDTH bits), 1100 BEQ, 1101 BNE, 1110 BLT (signed), 1111 BGE (signed); any other code SHALL give result 0 and cond 0.
REQ-017 SHALL form operand B as use_imm ? sign-extend(imm) : rs2; the immediate SHALL NOT be scaled.
REQ-018 SHALL use operand B[log2(WIDTH)-1:0] as the shift amount.
REQ-019 SHALL wrap ADD, SUB and MUL modulo 2^WIDTH with no overflow flag.
REQ-020 SHALL drive result = A - B and set cond from the comparison for branch ops; cond SHALL be 0 for non-branch ops.
REQ-021 SHALL implement the FSM states IDLE, MUL, DONE.
REQ-022 SHALL, in IDLE, drive in_ready = 1 and, on in_valid, latch op, the operands and branch; a non-MUL op SHALL compute and enter DONE on the next edge (latency 1); MUL SHALL enter MUL.
REQ-023 SHALL, in MUL, perform one shift-add step per cycle for exactly WIDTH cycles, then enter DONE (latency WIDTH+1), with in_ready = 0.
REQ-024 SHALL, in DONE, hold out_valid = 1 and result, cond and pcsrc stable until out_ready = 1; on that edge it SHALL return to IDLE.
REQ-025 SHALL keep in_ready = 0 in DONE (no acceptance while a result is pending); in_valid offered in DONE SHALL be ignored.
REQ-026 SHALL compute pcsrc = cond & branch_latched and drive it only while out_valid = 1, otherwise 0.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, in_ready 1, out_valid 0, result 0, cond 0, pcsrc 0, and clear the MUL counter and accumulators.
REQ-028 SHALL abandon an in-flight MUL or an unconsumed DONE result on reset, with no output produced after reset release.

Structure
REQ-029 SHALL take the op encodings and the FSM state enum from the shared package alu_pkg.
REQ-030 SHALL place the iterative multiplier in sub-module alu_mul_seq (start, done, WIDTH parameter).

Verification
REQ-031 SHALL check: ADD with rs1=5, use_imm=1, imm=12'hFFC -> result 1 one cycle later, cond 0.
REQ-032 SHALL check: MUL with rs1=32'hFFFF_FFFF, rs2=3 -> out_valid after 33 cycles, result 32'hFFFF_FFFD, in_ready 0 throughout.
REQ-033 SHALL check: BLT, branch=1, rs1=-2, rs2=1 -> cond 1, pcsrc 1; BGE with the same operands -> cond 0, pcsrc 0.
REQ-034 SHALL check: SRA with rs1=32'h8000_0000, rs2=33 -> result 32'hC000_0000 (shift of 1).
REQ-035 SHALL check: with out_ready held 0 for 5 cycles after DONE -> result held stable, second in_valid ignored, then out_ready=1 -> IDLE.
REQ-036 SHALL check: rst_n asserted at MUL step 10 -> outputs at reset values immediately, and the next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and
// the control FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;
  localparam logic [3:0] OP_BLT = 4'b1110;
  localparam logic [3:0] OP_BGE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial
// product per cycle, WIDTH cycles, low WIDTH bits.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  // Next accumulator; exposed so the last step
  // can be captured on the same edge it completes.
  always_comb begin
    acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o = busy_q & (cnt_q == LAST);
    prod_o = acc_d;
  end

  // Operand load on start, then one step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with branch compare and an
// iterative multiplier behind a valid/ready pair.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             use_imm,
  input  logic             branch,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cond,
  output logic             pcsrc
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] result_q;
  logic             cond_q;
  logic             br_q;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   sh;
  logic             lt_s;
  logic             eq;
  logic [WIDTH-1:0] res_c;
  logic             cond_c;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  // Operand B select and shared compare terms.
  always_comb begin
    b_op = use_imm
         ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm}
         : rs2;
    diff = rs1 - b_op;
    sh   = b_op[SHW-1:0];
    lt_s = $signed(rs1) < $signed(b_op);
    eq   = (rs1 == b_op);
  end

  // Single-cycle ALU; unknown codes give 0/0.
  always_comb begin
    res_c  = '0;
    cond_c = 1'b0;
    case (op)
      OP_AND: res_c = rs1 & b_op;
      OP_OR:  res_c = rs1 | b_op;
      OP_ADD: res_c = rs1 + b_op;
      OP_SUB: res_c = diff;
      OP_XOR: res_c = rs1 ^ b_op;
      OP_SRA: res_c = $signed(rs1) >>> sh;
      OP_SLL: res_c = rs1 << sh;
      OP_SRL: res_c = rs1 >> sh;
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, lt_s};
      OP_BEQ: begin
        res_c  = diff;
        cond_c = eq;
      end
      OP_BNE: begin
        res_c  = diff;
        cond_c = !eq;
      end
      OP_BLT: begin
        res_c  = diff;
        cond_c = lt_s;
      end
      OP_BGE: begin
        res_c  = diff;
        cond_c = !lt_s;
      end
      default: ;
    endcase
  end

  assign accept    = in_valid & (state_q == ST_IDLE);
  assign mul_start = accept & (op == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (rs1),
    .b_i     (b_op),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)
        state_d = (op == OP_MUL) ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_done)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; pcsrc only while a result is held.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    pcsrc     = out_valid & cond_q & br_q;
    result    = result_q;
    cond      = cond_q;
  end

  // Result capture: on accept for 1-cycle ops,
  // on the final step for MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      cond_q   <= 1'b0;
      br_q     <= 1'b0;
    end else if (accept) begin
      br_q     <= branch;
      result_q <= res_c;
      cond_q   <= cond_c;
    end else if (mul_done) begin
      result_q <= mul_prod;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Vector table + scoreboard bench for alu_mc.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        use_imm;
  logic        branch;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [11:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cond;
  logic        pcsrc;

  alu_mc #(.WIDTH(32), .IMM_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .use_imm   (use_imm),
    .branch    (branch),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cond      (cond),
    .pcsrc     (pcsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        ui;
    logic        br;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] imm;
    logic [31:0] res;
    logic        cnd;
    logic        pc;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        cnd;
    logic        pc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  vec_t tbl[19];

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h",
               nm, got, want);
    end
  endtask

  // Scoreboard: compare at each output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_spurious", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_res", 64'(result), 64'(e.res));
        chk("sb_cond", 64'(cond), 64'(e.cnd));
        chk("sb_pcsrc", 64'(pcsrc), 64'(e.pc));
      end
    end
  end

  task automatic drive(vec_t v);
    op      = v.op;
    use_imm = v.ui;
    branch  = v.br;
    rs1     = v.a;
    rs2     = v.b;
    imm     = v.imm;
  endtask

  // Issue one op from idle, check latency and
  // in_ready low until the result is consumed.
  task automatic do_op(int idx, vec_t v);
    exp_t e;
    int   n;
    bit   bad;
    chk($sformatf("v%0d_rdy", idx),
        64'(in_ready), 64'd1);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    e.res = v.res;
    e.cnd = v.cnd;
    e.pc  = v.pc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n   = 1;
    bad = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (in_ready) bad = 1'b1;
    chk($sformatf("v%0d_lat", idx),
        64'(n), 64'(v.lat));
    chk($sformatf("v%0d_busy", idx),
        64'(bad), 64'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle", idx),
        64'(out_valid), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   bad;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    use_imm   = 1'b0;
    branch    = 1'b0;
    rs1       = '0;
    rs2       = '0;
    imm       = '0;

    tbl[0]  = '{OP_ADD, 1, 0, 32'd5, 32'd0,
                12'hFFC, 32'd1, 0, 0, 1};
    tbl[1]  = '{OP_SUB, 0, 0, 32'd10, 32'd3,
                12'h0, 32'd7, 0, 0, 1};
    tbl[2]  = '{OP_AND, 0, 0, 32'hF0F0, 32'h0FF0,
                12'h0, 32'h00F0, 0, 0, 1};
    tbl[3]  = '{OP_OR, 0, 0, 32'hF0F0, 32'h0FF0,
                12'h0, 32'hFFF0, 0, 0, 1};
    tbl[4]  = '{OP_XOR, 0, 0, 32'hF0F0, 32'h0FF0,
                12'h0, 32'hFF00, 0, 0, 1};
    tbl[5]  = '{OP_SRA, 0, 0, 32'h8000_0000, 32'd33,
                12'h0, 32'hC000_0000, 0, 0, 1};
    tbl[6]  = '{OP_SLL, 0, 0, 32'd1, 32'd4,
                12'h0, 32'd16, 0, 0, 1};
    tbl[7]  = '{OP_SRL, 0, 0, 32'h8000_0000, 32'd4,
                12'h0, 32'h0800_0000, 0, 0, 1};
    tbl[8]  = '{OP_SLT, 0, 0, 32'hFFFF_FFFF, 32'd1,
                12'h0, 32'd1, 0, 0, 1};
    tbl[9]  = '{OP_SLT, 0, 0, 32'd1, 32'hFFFF_FFFF,
                12'h0, 32'd0, 0, 0, 1};
    tbl[10] = '{OP_MUL, 0, 0, 32'hFFFF_FFFF, 32'd3,
                12'h0, 32'hFFFF_FFFD, 0, 0, 33};
    tbl[11] = '{OP_MUL, 0, 0, 32'h1234, 32'h5678,
                12'h0, 32'h0626_0060, 0, 0, 33};
    tbl[12] = '{OP_BLT, 0, 1, 32'hFFFF_FFFE, 32'd1,
                12'h0, 32'hFFFF_FFFD, 1, 1, 1};
    tbl[13] = '{OP_BGE, 0, 1, 32'hFFFF_FFFE, 32'd1,
                12'h0, 32'hFFFF_FFFD, 0, 0, 1};
    tbl[14] = '{OP_BEQ, 0, 1, 32'd7, 32'd7,
                12'h0, 32'd0, 1, 1, 1};
    tbl[15] = '{OP_BNE, 0, 0, 32'd7, 32'd8,
                12'h0, 32'hFFFF_FFFF, 1, 0, 1};
    tbl[16] = '{4'b0011, 0, 1, 32'd9, 32'd9,
                12'h0, 32'd0, 0, 0, 1};
    tbl[17] = '{OP_ADD, 1, 0, 32'd1, 32'd0,
                12'h7FF, 32'h800, 0, 0, 1};
    tbl[18] = '{OP_ADD, 0, 0, 32'hFFFF_FFFF, 32'd1,
                12'h0, 32'd0, 0, 0, 1};

    #3;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_cond", 64'(cond), 64'd0);
    chk("rst_pc", 64'(pcsrc), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) do_op(i, tbl[i]);

    // Result held while the consumer stalls;
    // an offer made during DONE is dropped.
    out_ready = 1'b0;
    drive(tbl[4]);
    in_valid = 1'b1;
    sb.push_back('{32'hFF00, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_ov0", 64'(out_valid), 64'd1);
    drive(tbl[0]);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_rdy%0d", i),
          64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("hold_ov%0d", i),
          64'(out_valid), 64'd1);
      chk($sformatf("hold_res%0d", i),
          64'(result), 64'hFF00);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_rel_ov", 64'(out_valid), 64'd0);
    chk("hold_rel_rdy", 64'(in_ready), 64'd1);
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    chk("hold_dropped", 64'(bad), 64'd0);

    // Reset during a multiply abandons it.
    v = tbl[11];
    drive(v);
    in_valid = 1'b1;
    sb.push_back('{v.res, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("mrst_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mrst_rdy", 64'(in_ready), 64'd1);
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_res", 64'(result), 64'd0);
    chk("mrst_cond", 64'(cond), 64'd0);
    chk("mrst_pc", 64'(pcsrc), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bad = 0;
    repeat (40) begin
      if (out_valid || !in_ready) bad++;
      @(posedge clk); #1;
    end
    chk("mrst_quiet", 64'(bad), 64'd0);
    do_op(100, tbl[0]);
    do_op(101, tbl[10]);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
